// File: rtl/mem_ctrl.sv
// Data-memory stage behind the MDR: one read or write per transaction, performed after
// WAIT_STATES wait cycles, with registered done / rdata_valid / err pulses.
module mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_L  = 4'(WAIT_STATES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              op_wr_q;
    logic              busy_q;
    logic              done_q;
    logic              rvalid_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range_d;
    logic              accept_d;
    logic              reject_d;
    logic              access_d;
    logic [IDX_W-1:0]  idx_d;

    // Request qualification and access-edge decode
    always_comb begin
        in_range_d = 1'b0;
        accept_d   = 1'b0;
        reject_d   = 1'b0;
        access_d   = 1'b0;
        idx_d      = addr_q[IDX_W-1:0];
        in_range_d = (32'(addr) < 32'(DEPTH));
        if (state_q == ST_IDLE) begin
            accept_d = (rd_req ^ wr_req) && in_range_d;
            reject_d = (rd_req && wr_req) || ((rd_req || wr_req) && !in_range_d);
        end else begin
            accept_d = 1'b0;
            reject_d = 1'b0;
        end
        access_d = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    end

    // Transaction FSM with registered status outputs; pulses self-clear every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            op_wr_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        op_wr_q <= wr_req;
                        cnt_q   <= WS_L;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else if (reject_d) begin
                        err_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!op_wr_q) begin
                            rdata_q  <= mem_q[idx_d];
                            rvalid_q <= 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array: not reset; a write only lands on its access edge
    always_ff @(posedge clk) begin
        if (!reset && access_d && op_wr_q) begin
            mem_q[idx_d] <= wdata_q;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: instance 0 has DEPTH=16/WAIT_STATES=2,
// instance 1 has DEPTH=256/WAIT_STATES=0.
module tb_mem_ctrl;

    logic        clk;
    logic        rst    [2];
    logic [7:0]  addr   [2];
    logic [15:0] wdata  [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [15:0] rdata  [2];
    logic        rv     [2];
    logic        busy   [2];
    logic        done   [2];
    logic        err    [2];

    int checks;
    int failures;

    mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(2)) u_a (
        .clk(clk), .reset(rst[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rd_req(rd[0]), .wr_req(wr[0]), .rdata(rdata[0]), .rdata_valid(rv[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_b (
        .clk(clk), .reset(rst[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rd_req(rd[1]), .wr_req(wr[1]), .rdata(rdata[1]), .rdata_valid(rv[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance s; request edge N, done at edge N+ws+1, idle at N+ws+2.
    task automatic txn(input int s, input bit is_wr, input logic [7:0] a,
                       input logic [15:0] d, input int ws, input logic [15:0] exp_rdata);
        addr[s]  = a;
        wdata[s] = d;
        rd[s]    = !is_wr;
        wr[s]    = is_wr;
        step();
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        chk("txn_busy_accept", 32'(busy[s]), 32'd1);
        for (int i = 0; i < ws; i++) begin
            chk("txn_done_early", 32'(done[s]), 32'd0);
            step();
        end
        chk("txn_done_early", 32'(done[s]), 32'd0);
        step();
        chk("txn_done", 32'(done[s]), 32'd1);
        chk("txn_busy_done", 32'(busy[s]), 32'd1);
        chk("txn_rvalid", 32'(rv[s]), is_wr ? 32'd0 : 32'd1);
        chk("txn_rdata", 32'(rdata[s]), 32'(exp_rdata));
        step();
        chk("txn_busy_end", 32'(busy[s]), 32'd0);
        chk("txn_done_end", 32'(done[s]), 32'd0);
        chk("txn_rdata_hold", 32'(rdata[s]), 32'(exp_rdata));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; addr[s] = 8'h00; wdata[s] = 16'h0000; rd[s] = 1'b0; wr[s] = 1'b0;
        end
        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_done", 32'(done[0]), 32'd0);
        chk("reset_rvalid", 32'(rv[0]), 32'd0);
        chk("reset_err", 32'(err[0]), 32'd0);
        chk("reset_rdata", 32'(rdata[0]), 32'h0000);

        // Write then read back; rdata must not move on the write
        txn(0, 1'b1, 8'h05, 16'h00AB, 2, 16'h0000);
        txn(0, 1'b0, 8'h05, 16'h0000, 2, 16'h00AB);
        step();
        chk("rdata_hold_idle", 32'(rdata[0]), 32'h00AB);

        // Simultaneous rd/wr is rejected for exactly one cycle
        addr[0] = 8'h05; wdata[0] = 16'hFFFF; rd[0] = 1'b1; wr[0] = 1'b1;
        step();
        rd[0] = 1'b0; wr[0] = 1'b0;
        chk("both_err", 32'(err[0]), 32'd1);
        chk("both_busy", 32'(busy[0]), 32'd0);
        step();
        chk("both_err_clear", 32'(err[0]), 32'd0);
        txn(0, 1'b0, 8'h05, 16'h0000, 2, 16'h00AB);

        // Out of range (DEPTH=16): 0x20 aliases word 0 if the range check were missing
        txn(0, 1'b1, 8'h00, 16'h0000, 2, 16'h00AB);
        addr[0] = 8'h20; wdata[0] = 16'h5555; wr[0] = 1'b1;
        step();
        wr[0] = 1'b0;
        chk("oor_err", 32'(err[0]), 32'd1);
        chk("oor_busy", 32'(busy[0]), 32'd0);
        step();
        chk("oor_err_clear", 32'(err[0]), 32'd0);
        txn(0, 1'b0, 8'h00, 16'h0000, 2, 16'h0000);
        txn(0, 1'b1, 8'h0F, 16'h1234, 2, 16'h0000);
        txn(0, 1'b0, 8'h0F, 16'h0000, 2, 16'h1234);

        // Reset one cycle after a write request, before its access edge
        txn(0, 1'b1, 8'h07, 16'h0000, 2, 16'h1234);
        addr[0] = 8'h07; wdata[0] = 16'hBEEF; wr[0] = 1'b1;
        step();
        wr[0] = 1'b0;
        chk("midwr_busy_before", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("midwr_busy", 32'(busy[0]), 32'd0);
        chk("midwr_done", 32'(done[0]), 32'd0);
        chk("midwr_rdata", 32'(rdata[0]), 32'h0000);
        step();
        step();
        step();
        chk("midwr_idle_done", 32'(done[0]), 32'd0);
        chk("midwr_idle_busy", 32'(busy[0]), 32'd0);
        txn(0, 1'b0, 8'h07, 16'h0000, 2, 16'h0000);

        // WAIT_STATES=0: held rd_req repeats every 3 cycles, no err while busy
        txn(1, 1'b1, 8'h03, 16'h0C0D, 0, 16'h0000);
        addr[1] = 8'h03; rd[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_accept_busy", 32'(busy[1]), 32'd1);
            chk("hold_accept_done", 32'(done[1]), 32'd0);
            chk("hold_err_wait", 32'(err[1]), 32'd0);
            step();
            chk("hold_done", 32'(done[1]), 32'd1);
            chk("hold_rvalid", 32'(rv[1]), 32'd1);
            chk("hold_rdata", 32'(rdata[1]), 32'h0C0D);
            chk("hold_err_done", 32'(err[1]), 32'd0);
            step();
            chk("hold_idle_busy", 32'(busy[1]), 32'd0);
            chk("hold_idle_done", 32'(done[1]), 32'd0);
            chk("hold_idle_err", 32'(err[1]), 32'd0);
        end
        rd[1] = 1'b0;
        step();
        step();
        step();
        chk("hold_release_busy", 32'(busy[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
